// File: rtl/fib_rec_seq.sv
// fib_rec_seq
// ---------------------------------------------------------------------------
// Sequential Fibonacci recogniser. A start request captures an unsigned
// operand, then the sequence F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2) is walked one
// term per clock. The search stops at the first term that equals the operand
// (reporting its index) or exceeds it (reporting "not Fibonacci").
//
// Parameters
//   WIDTH  operand width in bits (4..16)
//   IDX_W  width of fib_index; 5 bits covers every WIDTH up to 16
//
// Ports
//   clk        rising-edge system clock
//   reset_n    asynchronous active-low reset
//   start      search request, only looked at while idle
//   number     operand, captured on the edge that accepts start
//   abort      synchronous cancel, only effective while searching
//   busy       high while the search is running
//   done       one-cycle pulse marking a fresh result
//   is_fib     1 when the last completed operand is a Fibonacci number
//   fib_index  lowest k with F(k)=operand, 0 when is_fib=0
// ---------------------------------------------------------------------------
module fib_rec_seq #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] fib_index
);

  // Controller states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Terms carry two guard bits: while searching a < 2^WIDTH and b <= 2a+1,
  // so the next sum stays below 2^(WIDTH+2) and never wraps.
  localparam int TW = WIDTH + 2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [TW-1:0]    a_q, a_d;
  logic [TW-1:0]    b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             is_fib_q, is_fib_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [TW-1:0]    num_ext;
  logic             hit;
  logic             over;

  // Operand zero-extended to the term width for the two comparisons.
  assign num_ext = {2'b00, num_q};
  assign hit     = (a_q == num_ext);
  assign over    = (a_q > num_ext);

  // Next-state and datapath decisions. In SEARCH the checks are ordered
  // abort, match, exceed, advance. busy/done are computed one cycle ahead so
  // that they come straight out of flops and line up with the state.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    is_fib_d = is_fib_q;
    idx_d    = idx_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = number;
          a_d     = '0;
          b_d     = {{(TW-1){1'b0}}, 1'b1};
          k_d     = '0;
          state_d = ST_SEARCH;
          busy_d  = 1'b1;
        end
      end

      ST_SEARCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          // The first hit wins, so operand 1 reports index 1, not 2.
          is_fib_d = 1'b1;
          idx_d    = k_q;
          state_d  = ST_DONE;
          done_d   = 1'b1;
        end else if (over) begin
          is_fib_d = 1'b0;
          idx_d    = '0;
          state_d  = ST_DONE;
          done_d   = 1'b1;
        end else begin
          a_d    = b_q;
          b_d    = a_q + b_q;
          busy_d = 1'b1;
          if (k_q != {IDX_W{1'b1}}) begin
            k_d = k_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state lives here; reset clears everything immediately, which also
  // kills any search in flight without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_fib_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_fib_q <= is_fib_d;
      idx_q    <= idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign is_fib    = is_fib_q;
  assign fib_index = idx_q;

endmodule

// File: tb/tb_fib_rec_seq.sv
// tb_fib_rec_seq
// ---------------------------------------------------------------------------
// Directed bench for fib_rec_seq at WIDTH=8. Each scenario is its own task
// with hand-computed expected latency and results.
// ---------------------------------------------------------------------------
module tb_fib_rec_seq;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] number;
  logic       abort;
  logic       busy;
  logic       done;
  logic       is_fib;
  logic [4:0] fib_index;

  int errors;
  int checks;

  // Result the bench expects the DUT to be holding from the last search.
  logic       prevFib;
  logic [4:0] prevIdx;

  fib_rec_seq #(.WIDTH(8), .IDX_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .number    (number),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .is_fib    (is_fib),
    .fib_index (fib_index)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the sequence of tasks.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Requests one search; returns at the negedge just after the accepting edge.
  task automatic startOp(input logic [7:0] n);
    @(negedge clk);
    start  = 1'b1;
    number = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Runs one search and checks latency, busy length, result and pulse width.
  task automatic runSearch(input string name, input logic [7:0] n, input int expEdges,
                           input logic expFib, input logic [4:0] expIdx);
    int edges;
    int busyCnt;
    startOp(n);
    edges   = 0;
    busyCnt = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== expEdges) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d edges expected %0d", name, edges, expEdges);
    end
    checks++;
    if (busyCnt !== expEdges) begin
      errors++;
      $display("[TB] FAIL %s_busy_len: got %0d cycles expected %0d", name, busyCnt, expEdges);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy_with_done: got %b expected 0", name, busy);
    end
    checks++;
    if (is_fib !== expFib) begin
      errors++;
      $display("[TB] FAIL %s_is_fib: got %b expected %b", name, is_fib, expFib);
    end
    checks++;
    if (fib_index !== expIdx) begin
      errors++;
      $display("[TB] FAIL %s_fib_index: got %0d expected %0d", name, fib_index, expIdx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_width: got %b expected 0", name, done);
    end
    prevFib = expFib;
    prevIdx = expIdx;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    number  = 8'd0;
    #12;
    checks++;
    if ({busy, done, is_fib, fib_index} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000000", {busy, done, is_fib, fib_index});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b expected 00", {busy, done});
    end
    prevFib = 1'b0;
    prevIdx = 5'd0;
  endtask

  task automatic test_matches();
    runSearch("zero", 8'd0,   1,  1'b1, 5'd0);
    runSearch("n13",  8'd13,  8,  1'b1, 5'd7);
    runSearch("n1",   8'd1,   2,  1'b1, 5'd1);
    runSearch("n233", 8'd233, 14, 1'b1, 5'd13);
  endtask

  task automatic test_non_fib();
    runSearch("n4",   8'd4,   6,  1'b0, 5'd0);
    runSearch("n255", 8'd255, 15, 1'b0, 5'd0);
  endtask

  // Start pulses and operand changes during SEARCH must not disturb the run.
  task automatic test_ignored_start();
    int edges;
    int pulses;
    startOp(8'd13);
    start  = 1'b1;
    number = 8'd4;
    @(negedge clk);
    start  = 1'b0;
    number = 8'd99;
    edges  = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 8) begin
      errors++;
      $display("[TB] FAIL ign_latency: got %0d edges expected 8", edges);
    end
    checks++;
    if ({is_fib, fib_index} !== {1'b1, 5'd7}) begin
      errors++;
      $display("[TB] FAIL ign_result: got fib=%b idx=%0d expected fib=1 idx=7", is_fib, fib_index);
    end
    pulses = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL ign_pulses: got %0d done pulses expected 1", pulses);
    end
    prevFib = 1'b1;
    prevIdx = 5'd7;
  endtask

  task automatic test_abort();
    logic sawDone;
    startOp(8'd233);
    sawDone = (done === 1'b1);
    @(negedge clk);
    sawDone = sawDone | (done === 1'b1);
    @(negedge clk);
    sawDone = sawDone | (done === 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_idle: got busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if ({is_fib, fib_index} !== {prevFib, prevIdx}) begin
      errors++;
      $display("[TB] FAIL abort_hold: got fib=%b idx=%0d expected fib=%b idx=%0d",
               is_fib, fib_index, prevFib, prevIdx);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sawDone = sawDone | (done === 1'b1);
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done pulse expected none");
    end
    runSearch("n21", 8'd21, 9, 1'b1, 5'd8);
  endtask

  task automatic test_async_reset();
    logic sawDone;
    startOp(8'd233);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, is_fib, fib_index} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL areset_outputs: got %b expected 00000000", {busy, done, is_fib, fib_index});
    end
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sawDone = sawDone | (done === 1'b1) | (busy === 1'b1);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sawDone = sawDone | (done === 1'b1);
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_no_done: got activity expected none");
    end
    prevFib = 1'b0;
    prevIdx = 5'd0;
    runSearch("n5", 8'd5, 6, 1'b1, 5'd5);
  endtask

  // Holding start with operand 1: SEARCH, SEARCH, DONE, IDLE, repeat.
  task automatic test_back_to_back();
    logic [7:0] gotBusy;
    logic [7:0] gotDone;
    logic [7:0] expBusy;
    logic [7:0] expDone;
    expBusy = 8'b00110011;
    expDone = 8'b01000100;
    @(negedge clk);
    start  = 1'b1;
    number = 8'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gotBusy[i] = busy;
      gotDone[i] = done;
    end
    start = 1'b0;
    checks++;
    if (gotBusy !== expBusy) begin
      errors++;
      $display("[TB] FAIL b2b_busy: got %b expected %b", gotBusy, expBusy);
    end
    checks++;
    if (gotDone !== expDone) begin
      errors++;
      $display("[TB] FAIL b2b_done: got %b expected %b", gotDone, expDone);
    end
    checks++;
    if ({is_fib, fib_index} !== {1'b1, 5'd1}) begin
      errors++;
      $display("[TB] FAIL b2b_result: got fib=%b idx=%0d expected fib=1 idx=1", is_fib, fib_index);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_matches();
    test_non_fib();
    test_ignored_start();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
